// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM pipeline stage running loads/stores over a req/ack data bus
//
// Sits between EX/MEM and MEM/WB. Non-memory operations pass straight
// through combinationally. Aligned loads and stores raise stallreq_o, issue
// one registered bus access and present the (formatted) result once the bus
// acknowledges or the access times out.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   stall          ctrl stall vector; stall[4] holds MEM/WB (and this stage in DONE)
//   wd_i/wreg_i/wdata_i   destination, write enable and ALU result from EX/MEM
//   memop_i        0 none,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 SB,7 SH,8 SW, 9-15 none
//   addr_i         effective byte address
//   sdata_i        store data
//   wd_o/wreg_o/wdata_o   result towards MEM/WB and ID forwarding
//   stallreq_o     stall request to ctrl
//   bus_*_o        registered bus request, write flag, word address, byte
//                  enables (bit 3 = bits 31:24) and lane-replicated store data
//   bus_ack_i      access complete, bus_rdata_i valid in the same cycle
//   bus_rdata_i    read data
//   misalign_o     current operation is misaligned (combinational)
//   timeout_o      one-cycle pulse when an access is aborted

module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  memop_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] sdata_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        misalign_o,
    output logic        timeout_o
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    // Counter holds 0..TIMEOUT-1 BUSY cycles already spent without ack.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      result_q;
    logic             aborted_q;

    logic             is_load;
    logic             is_store;
    logic             size_byte;
    logic             size_half;
    logic             size_word;
    logic             misalign;
    logic             mem_go;
    logic [3:0]       sel_c;
    logic [31:0]      store_c;
    logic [7:0]       byte_lane;
    logic [15:0]      half_lane;
    logic [31:0]      load_fmt;

    logic             stall_c;
    logic             launch;
    logic             ack_take;
    logic             abort_now;

    // Only stall[4] matters to this stage.
    logic             unused_stall;
    assign unused_stall = ^{stall[5], stall[3:0]};

    // ---------------------------------------------------------------
    // Operation decode
    // ---------------------------------------------------------------
    always_comb begin
        is_load   = (memop_i >= OP_LB) && (memop_i <= OP_LW);
        is_store  = (memop_i >= OP_SB) && (memop_i <= OP_SW);
        size_byte = (memop_i == OP_LB) || (memop_i == OP_LBU) || (memop_i == OP_SB);
        size_half = (memop_i == OP_LH) || (memop_i == OP_LHU) || (memop_i == OP_SH);
        size_word = (memop_i == OP_LW) || (memop_i == OP_SW);
        misalign  = (size_half && addr_i[0]) || (size_word && (addr_i[1:0] != 2'b00));
        mem_go    = (is_load || is_store) && !misalign;
    end

    assign misalign_o = misalign;

    // Big-endian lanes: byte address 0 lives in bits 31:24.
    always_comb begin
        sel_c   = 4'b0000;
        store_c = sdata_i;
        if (size_byte) begin
            sel_c   = 4'b1000 >> addr_i[1:0];
            store_c = {4{sdata_i[7:0]}};
        end else if (size_half) begin
            sel_c   = addr_i[1] ? 4'b0011 : 4'b1100;
            store_c = {2{sdata_i[15:0]}};
        end else if (size_word) begin
            sel_c   = 4'b1111;
            store_c = sdata_i;
        end
    end

    always_comb begin
        case (addr_i[1:0])
            2'd0:    byte_lane = bus_rdata_i[31:24];
            2'd1:    byte_lane = bus_rdata_i[23:16];
            2'd2:    byte_lane = bus_rdata_i[15:8];
            default: byte_lane = bus_rdata_i[7:0];
        endcase
        half_lane = addr_i[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];

        case (memop_i)
            OP_LB:   load_fmt = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  load_fmt = {24'd0, byte_lane};
            OP_LH:   load_fmt = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  load_fmt = {16'd0, half_lane};
            default: load_fmt = bus_rdata_i;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state and outputs
    // ---------------------------------------------------------------
    always_comb begin
        next_state = state;
        stall_c    = 1'b0;
        launch     = 1'b0;
        ack_take   = 1'b0;
        abort_now  = 1'b0;
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;

        case (state)
            IDLE: begin
                if (mem_go) begin
                    stall_c    = 1'b1;
                    wreg_o     = 1'b0;
                    launch     = 1'b1;
                    next_state = BUSY;
                end else if (misalign) begin
                    wreg_o = 1'b0;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                wreg_o  = 1'b0;
                // Ack wins over a timeout landing in the same cycle.
                if (bus_ack_i) begin
                    ack_take   = 1'b1;
                    next_state = DONE;
                end else if (wait_cnt == CNT_LAST) begin
                    abort_now  = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (is_load) begin
                    wdata_o = result_q;
                    wreg_o  = wreg_i && !aborted_q;
                end
                if (!stall[4]) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Reset forces IDLE asynchronously, but the IDLE decode still sees the
    // held memory op; mask it so ctrl is released without waiting for an edge.
    assign stallreq_o = stall_c && !rst;

    // ---------------------------------------------------------------
    // Bus registers, timeout counter and result
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'd0;
            bus_sel_o   <= 4'd0;
            bus_wdata_o <= 32'd0;
            timeout_o   <= 1'b0;
            wait_cnt    <= '0;
            result_q    <= 32'd0;
            aborted_q   <= 1'b0;
        end else begin
            timeout_o <= abort_now;
            if (launch) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= is_store;
                bus_addr_o  <= {addr_i[31:2], 2'b00};
                bus_sel_o   <= sel_c;
                bus_wdata_o <= store_c;
                wait_cnt    <= '0;
                aborted_q   <= 1'b0;
            end else if (ack_take) begin
                bus_req_o <= 1'b0;
                result_q  <= load_fmt;
            end else if (abort_now) begin
                bus_req_o <= 1'b0;
                aborted_q <= 1'b1;
            end else if (state == BUSY) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

endmodule
